fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that sequences the combinational instruction ROM for the LEGv8 core. Owns the program counter, drives the ROM word address and buffers fetched words in a small queue. Presents them to decode over a valid/ready handshake. Supports branch redirect with flush and stops fetching when it fetches the halt word (BR XZR).

## Interface
- ADDR_W, 16: ROM word-address width; PC width.
- DATA_W, 32: instruction width.
- QDEPTH, 2: fetch-queue entries, power of two, ≥2.
- RESET_PC, 16'h0000: PC loaded at reset.
- HALT_INSN, 32'hD60003E0: instruction word that ends fetching.
- clk, in, 1: single clock, all state on rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle pulse that begins fetching from the current PC.
- rom_addr, out, ADDR_W: ROM word address; always equals the PC register.
- rom_data, in, DATA_W: ROM word for rom_addr, valid in the same cycle.
- redirect_valid, in, 1: branch/jump taken.
- redirect_pc, in, ADDR_W: target word address.
- inst_valid, out, 1: queue head valid.
- inst_ready, in, 1: decode accepts the head.
- inst, out, DATA_W: head instruction.
- inst_pc, out, ADDR_W: word address of the head instruction.
- halted, out, 1: halt word fetched, queue drained.

## Operation
- States:
  - IDLE: no fetch.
  - FETCH: push one word per cycle when space exists.
  - HALT: no fetch.
- Reset values:
  - state=IDLE, pc=RESET_PC, queue empty.
  - inst_valid=0, inst=0, inst_pc=0, halted=0.
- IDLE→FETCH on start. start in FETCH or HALT is ignored.
- Push condition in FETCH: count<QDEPTH, or (count==QDEPTH and the head pops this cycle).
- On push:
  - Enqueue {pc, rom_data}.
  - pc ← pc+1, modulo 2^ADDR_W, so 16'hFFFF wraps to 16'h0000.
- If the pushed word equals HALT_INSN, it is enqueued and state→HALT. pc still increments.
- Queue full with no pop: no push, pc holds.
- Pop occurs when inst_valid && inst_ready.
- halted = (state==HALT) && queue empty, registered.
- Redirect has priority over everything in the same cycle. In any state it:
  - flushes the queue, including any same-cycle push; a same-cycle pop still counts as accepted by decode;
  - sets pc ← redirect_pc;
  - sets state → FETCH;
  - clears halted.
- Redirect in IDLE therefore also starts fetching.
- Reset asserted mid-operation clears everything asynchronously. Fetch resumes only after a new start.

## Timing
- Queue is registered, with no ROM-to-output combinational path; inst/inst_pc come from flops.
- Latency from start pulse (cycle 0):
  - cycle 1: FETCH, rom_addr=pc, push at end of cycle;
  - cycle 2: inst_valid=1.
- Sustained throughput is 1 instruction/cycle while inst_ready=1.
- Redirect in cycle N:
  - inst_valid=0 in cycle N+1, rom_addr=redirect_pc in cycle N+1;
  - target instruction valid in cycle N+2.
- inst/inst_pc hold stable while inst_valid && !inst_ready.
- halted rises the cycle after the halt word is popped, provided the queue is empty then.

## Structure
- Package fetch_pkg holds:
  - state enum {IDLE, FETCH, HALT};
  - HALT_INSN and RESET_PC defaults;
  - the queue entry struct {pc, insn}.
- Sub-module fetch_queue: synchronous FIFO of QDEPTH entries.
  - Ports: push, pop, flush, full, empty, head.
  - Flush dominates push.
- Top level holds the PC, the FSM and the halt detect.

## Test plan
- Straight-line, ready=1:
  - Stimulus: reset, start.
  - Required response, in order from cycle 2, one per cycle:
    - (pc0, F8400140)
    - (pc1, F8400161)
    - (pc2, 8B050083)
    - …
    - (pc7, F8000142)
    - (pc8, D60003E0)
  - Then no further valid; halted=1 one cycle after the last pop.
- Backpressure:
  - Stimulus: ready=0 for 5 cycles after start.
  - Required response: queue fills to 2, pc holds at 2, inst stays F8400140.
  - On ready=1: no word lost or duplicated, pc resumes at 2.
- Redirect:
  - Stimulus: redirect_valid with redirect_pc=5 while the queue holds pc3/pc4.
  - Required response: both entries flushed; next valid is (pc5, 8A050088) two cycles later.
- Redirect after halt:
  - Stimulus: with halted=1, redirect_pc=0.
  - Required response: halted clears next cycle; (pc0, F8400140) valid in cycle N+2.
- Wrap and reset:
  - Stimulus: RESET_PC=16'hFFFF, start.
  - Required response: pc FFFF, then 0000. The word fetched at FFFF is D60003E0, so the block halts.
  - Stimulus: assert rst_n=0 mid-stream.
  - Required response: all outputs 0 immediately, state IDLE.
- Simultaneous start and redirect in IDLE:
  - Required response: fetch begins at redirect_pc, not the old pc.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_QDEPTH = 2;

  // Word address the PC starts from after reset.
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;

  // BR XZR: the word that ends instruction fetching.
  localparam logic [31:0] DEF_HALT_INSN = 32'hD60003E0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } fetch_state_e;

  // One fetch-queue entry at the default widths: word address plus instruction.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO buffering fetched {pc, insn} entries for decode.
module fetch_queue #(
  parameter int ENTRY_W = 48,
  parameter int QDEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] din,
  output logic               full,
  output logic               empty,
  output logic [ENTRY_W-1:0] head
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem [QDEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(QDEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush && (!full || do_pop);

  // Storage, pointers and occupancy; flush empties the queue and wins over a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the ROM address, queues
// fetched words for decode and stops fetching once the halt word is fetched.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                QDEPTH    = DEF_QDEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC),
  parameter logic [DATA_W-1:0] HALT_INSN = DATA_W'(DEF_HALT_INSN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              halted
);

  fetch_state_e             state;
  logic [ADDR_W-1:0]        pc;
  logic                     full;
  logic                     empty;
  logic                     pop;
  logic                     push;
  logic                     halt_pop;
  logic [ADDR_W+DATA_W-1:0] head;

  assign rom_addr   = pc;
  assign inst_valid = !empty;
  assign inst_pc    = head[ADDR_W+DATA_W-1:DATA_W];
  assign inst       = head[DATA_W-1:0];
  assign pop        = inst_valid && inst_ready;
  assign push       = (state == FETCH) && !redirect_valid && (!full || pop);

  // The halt word is always the last entry queued, so popping it empties the queue.
  assign halt_pop   = pop && (inst == HALT_INSN);

  fetch_queue #(
    .ENTRY_W (ADDR_W + DATA_W),
    .QDEPTH  (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({pc, rom_data}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // PC, fetch state and halted flag; a redirect overrides every other update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else if (redirect_valid) begin
      state  <= FETCH;
      pc     <= redirect_pc;
      halted <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= FETCH;
        end
        FETCH: begin
          if (push) begin
            pc <= pc + ADDR_W'(1);
            if (rom_data == HALT_INSN) state <= HALT;
          end
        end
        HALT: begin
        end
        default: state <= IDLE;
      endcase
      halted <= (state == HALT) && (empty || halt_pop);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a small program ROM.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        inst_ready;
  logic [15:0] rom_addr;
  logic [31:0] rom_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [15:0] inst_pc;
  logic        halted;

  logic        w_start;
  logic [15:0] w_rom_addr;
  logic [31:0] w_rom_data;
  logic        w_inst_valid;
  logic [31:0] w_inst;
  logic [15:0] w_inst_pc;
  logic        w_halted;

  int total = 0;
  int bad   = 0;

  logic [31:0] prog [9] = '{32'hF8400140, 32'hF8400161, 32'h8B050083,
                            32'hCB050084, 32'hAA050085, 32'h8A050088,
                            32'h8B0A0109, 32'hF8000142, 32'hD60003E0};

  // Program ROM contents, with the halt word also placed at the top address.
  function automatic logic [31:0] rom_word(input logic [15:0] a);
    case (a)
      16'h0000: rom_word = 32'hF8400140;
      16'h0001: rom_word = 32'hF8400161;
      16'h0002: rom_word = 32'h8B050083;
      16'h0003: rom_word = 32'hCB050084;
      16'h0004: rom_word = 32'hAA050085;
      16'h0005: rom_word = 32'h8A050088;
      16'h0006: rom_word = 32'h8B0A0109;
      16'h0007: rom_word = 32'hF8000142;
      16'h0008: rom_word = 32'hD60003E0;
      16'hFFFF: rom_word = 32'hD60003E0;
      default:  rom_word = 32'h00000000;
    endcase
  endfunction

  assign rom_data   = rom_word(rom_addr);
  assign w_rom_data = rom_word(w_rom_addr);

  always #5 clk = ~clk;

  fetch_sequencer u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .halted         (halted)
  );

  fetch_sequencer #(.RESET_PC(16'hFFFF)) u_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (w_start),
    .rom_addr       (w_rom_addr),
    .rom_data       (w_rom_data),
    .redirect_valid (1'b0),
    .redirect_pc    (16'h0000),
    .inst_valid     (w_inst_valid),
    .inst_ready     (1'b1),
    .inst           (w_inst),
    .inst_pc        (w_inst_pc),
    .halted         (w_halted)
  );

  task automatic next_cycle;
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc_exp,
                            input logic [31:0] insn_exp);
    check_output({tag, "_valid"}, 32'(inst_valid), 1);
    check_output({tag, "_pc"}, 32'(inst_pc), pc_exp);
    check_output({tag, "_inst"}, inst, insn_exp);
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    w_start        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    inst_ready     = 1'b1;
    next_cycle;
    next_cycle;

    $display("[TB] reset state");
    check_output("rst_valid", 32'(inst_valid), 0);
    check_output("rst_inst", inst, 0);
    check_output("rst_pc", 32'(inst_pc), 0);
    check_output("rst_halted", 32'(halted), 0);
    check_output("rst_rom_addr", 32'(rom_addr), 0);
    check_output("rst_w_rom_addr", 32'(w_rom_addr), 32'hFFFF);
    check_output("rst_w_pc", 32'(w_inst_pc), 0);
    rst_n = 1'b1;
    next_cycle;

    $display("[TB] straight-line fetch");
    start = 1'b1;
    next_cycle;
    start = 1'b0;
    check_output("sl_c1_valid", 32'(inst_valid), 0);
    check_output("sl_c1_rom_addr", 32'(rom_addr), 0);
    for (int i = 0; i < 9; i++) begin
      next_cycle;
      check_head("sl_head", 32'(i), prog[i]);
      check_output("sl_halted_early", 32'(halted), 0);
    end
    next_cycle;
    check_output("sl_end_valid", 32'(inst_valid), 0);
    check_output("sl_end_halted", 32'(halted), 1);
    check_output("sl_end_rom_addr", 32'(rom_addr), 9);

    $display("[TB] redirect after halt");
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0000;
    next_cycle;
    redirect_valid = 1'b0;
    check_output("rh_n1_halted", 32'(halted), 0);
    check_output("rh_n1_valid", 32'(inst_valid), 0);
    check_output("rh_n1_rom_addr", 32'(rom_addr), 0);
    next_cycle;
    check_head("rh_n2", 0, 32'hF8400140);

    $display("[TB] mid-stream reset");
    #1;
    rst_n = 1'b0;
    #1;
    check_output("mr_valid", 32'(inst_valid), 0);
    check_output("mr_inst", inst, 0);
    check_output("mr_pc", 32'(inst_pc), 0);
    check_output("mr_halted", 32'(halted), 0);
    check_output("mr_rom_addr", 32'(rom_addr), 0);
    next_cycle;
    rst_n = 1'b1;
    next_cycle;
    next_cycle;
    check_output("mr_idle_valid", 32'(inst_valid), 0);
    check_output("mr_idle_rom_addr", 32'(rom_addr), 0);

    $display("[TB] backpressure");
    inst_ready = 1'b0;
    start      = 1'b1;
    next_cycle;
    start = 1'b0;
    next_cycle;
    for (int c = 3; c <= 5; c++) begin
      next_cycle;
      check_head("bp_hold", 0, 32'hF8400140);
      check_output("bp_rom_addr", 32'(rom_addr), 2);
    end
    inst_ready = 1'b1;
    next_cycle;
    check_head("bp_c6", 1, 32'hF8400161);
    check_output("bp_c6_rom_addr", 32'(rom_addr), 3);
    next_cycle;
    check_head("bp_c7", 2, 32'h8B050083);
    next_cycle;
    check_head("bp_c8", 3, 32'hCB050084);
    check_output("bp_c8_rom_addr", 32'(rom_addr), 5);

    $display("[TB] redirect with queued entries");
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0005;
    next_cycle;
    redirect_valid = 1'b0;
    check_output("rd_n1_valid", 32'(inst_valid), 0);
    check_output("rd_n1_rom_addr", 32'(rom_addr), 5);
    next_cycle;
    check_head("rd_n2", 5, 32'h8A050088);
    next_cycle;
    check_head("rd_n3", 6, 32'h8B0A0109);

    $display("[TB] start and redirect together in idle");
    rst_n = 1'b0;
    next_cycle;
    rst_n = 1'b1;
    next_cycle;
    start          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0007;
    next_cycle;
    start          = 1'b0;
    redirect_valid = 1'b0;
    check_output("sr_c1_valid", 32'(inst_valid), 0);
    check_output("sr_c1_rom_addr", 32'(rom_addr), 7);
    next_cycle;
    check_head("sr_c2", 7, 32'hF8000142);
    next_cycle;
    check_head("sr_c3", 8, 32'hD60003E0);
    check_output("sr_c3_halted", 32'(halted), 0);
    next_cycle;
    check_output("sr_c4_valid", 32'(inst_valid), 0);
    check_output("sr_c4_halted", 32'(halted), 1);

    $display("[TB] pc wrap from FFFF");
    w_start = 1'b1;
    next_cycle;
    w_start = 1'b0;
    check_output("wr_c1_rom_addr", 32'(w_rom_addr), 32'hFFFF);
    check_output("wr_c1_valid", 32'(w_inst_valid), 0);
    next_cycle;
    check_output("wr_c2_valid", 32'(w_inst_valid), 1);
    check_output("wr_c2_pc", 32'(w_inst_pc), 32'hFFFF);
    check_output("wr_c2_inst", w_inst, 32'hD60003E0);
    check_output("wr_c2_rom_addr", 32'(w_rom_addr), 0);
    next_cycle;
    check_output("wr_c3_valid", 32'(w_inst_valid), 0);
    check_output("wr_c3_halted", 32'(w_halted), 1);
    check_output("wr_c3_rom_addr", 32'(w_rom_addr), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
